fir_xifu_wb_buf: RTL

- Parametrised successor to the FIR XIFU writeback stage.
- Buffers up to DEPTH in-flight instructions from EX.
- Tracks, independently per entry, the XIF commit/kill and the memory result.
- Retires entries strictly in order: internal register-file writes, XIF result handshake with backpressure (rs1 autoincrement writeback) and kill signalling. Sits between the EX stage and the XIF result interface and the FIR regfile.

---
 rtl/fir_xifu_pkg.sv | 41 ++++
 rtl/fir_xifu_id_match.sv | 29 ++
 rtl/fir_xifu_wb_buf.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fir_xifu_pkg.sv
// Shared FIR XIFU types: opcode enum, regfile write payload and writeback
// buffer entry, plus default widths and depth for the writeback buffer.
package fir_xifu_pkg;

   localparam int unsigned FIR_XIFU_ID_WIDTH      = 4;
   localparam int unsigned FIR_XIFU_DATA_WIDTH    = 32;
   localparam int unsigned FIR_XIFU_RF_ADDR_WIDTH = 5;
   localparam int unsigned FIR_XIFU_WB_DEPTH      = 4;

   typedef enum logic [1:0] {
      INSTR_OTHER = 2'd0,
      XFIRLW      = 2'd1,
      XFIRSW      = 2'd2,
      XFIRDOTP    = 2'd3
   } fir_xifu_instr_t;

   typedef struct packed {
      logic                              write;
      logic [FIR_XIFU_RF_ADDR_WIDTH-1:0] rd;
      logic [FIR_XIFU_DATA_WIDTH-1:0]    result;
   } fir_xifu_wb2regfile_t;

   typedef struct packed {
      logic                              valid;
      fir_xifu_instr_t                   instr;
      logic [FIR_XIFU_ID_WIDTH-1:0]      id;
      logic [FIR_XIFU_DATA_WIDTH-1:0]    result;
      logic [FIR_XIFU_RF_ADDR_WIDTH-1:0] rd;
      logic [FIR_XIFU_RF_ADDR_WIDTH-1:0] rs1;
      logic [FIR_XIFU_DATA_WIDTH-1:0]    rdata;
      logic                              committed;
      logic                              killed;
      logic                              mem_done;
   } fir_xifu_wbbuf_entry_t;

   // Loads and stores need a memory result before they can retire.
   function automatic logic is_mem_instr(input fir_xifu_instr_t instr);
      return (instr == XFIRLW) || (instr == XFIRSW);
   endfunction

endpackage

// File: rtl/fir_xifu_id_match.sv
// Id CAM: compares an incoming id against all buffered ids plus the slot
// being pushed this cycle.
//   valid_i/id_i          : lookup request
//   entry_valid_i/id_i    : buffered entries (ids packed, entry 0 in LSBs)
//   push_valid_i/id_i     : entry being written this cycle
//   match_o[DEPTH-1:0]    : per-entry match, match_o[DEPTH] = push slot
module fir_xifu_id_match #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ID_WIDTH = 4
) (
   input  logic                      valid_i,
   input  logic [ID_WIDTH-1:0]       id_i,
   input  logic [DEPTH-1:0]          entry_valid_i,
   input  logic [DEPTH*ID_WIDTH-1:0] entry_id_i,
   input  logic                      push_valid_i,
   input  logic [ID_WIDTH-1:0]       push_id_i,
   output logic [DEPTH:0]            match_o
);

   always_comb begin
      match_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_o[i] = valid_i & entry_valid_i[i] &
                      (entry_id_i[i*ID_WIDTH +: ID_WIDTH] == id_i);
      end
      match_o[DEPTH] = valid_i & push_valid_i & (push_id_i == id_i);
   end

endmodule

// File: rtl/fir_xifu_wb_buf.sv
// FIR XIFU writeback buffer: holds up to DEPTH in-flight instructions from
// EX, tracks XIF commit/kill and memory results per entry, and retires
// strictly in order to the FIR regfile and the XIF result interface.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   ex2wb_*                      : instruction push from EX (ready = !full)
//   commit_*                     : XIF commit / kill by id
//   mem_result_*                 : XIF memory result by id
//   result_*                     : XIF result handshake (rs1 autoincrement)
//   wb2regfile_o                 : FIR regfile write
//   kill_o                       : pulse when a kill matches an entry
//   occupancy_o                  : number of valid entries
module fir_xifu_wb_buf
   import fir_xifu_pkg::*;
#(
   parameter int unsigned DEPTH         = FIR_XIFU_WB_DEPTH,
   parameter int unsigned ID_WIDTH      = FIR_XIFU_ID_WIDTH,
   parameter int unsigned DATA_WIDTH    = FIR_XIFU_DATA_WIDTH,
   parameter int unsigned RF_ADDR_WIDTH = FIR_XIFU_RF_ADDR_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     ex2wb_valid_i,
   output logic                     ex2wb_ready_o,
   input  fir_xifu_instr_t          ex2wb_instr_i,
   input  logic [ID_WIDTH-1:0]      ex2wb_id_i,
   input  logic [DATA_WIDTH-1:0]    ex2wb_result_i,
   input  logic [RF_ADDR_WIDTH-1:0] ex2wb_rd_i,
   input  logic [RF_ADDR_WIDTH-1:0] ex2wb_rs1_i,
   input  logic                     commit_valid_i,
   input  logic [ID_WIDTH-1:0]      commit_id_i,
   input  logic                     commit_kill_i,
   input  logic                     mem_result_valid_i,
   input  logic [ID_WIDTH-1:0]      mem_result_id_i,
   input  logic [DATA_WIDTH-1:0]    mem_result_rdata_i,
   output logic                     result_valid_o,
   input  logic                     result_ready_i,
   output logic [ID_WIDTH-1:0]      result_id_o,
   output logic [DATA_WIDTH-1:0]    result_data_o,
   output logic [RF_ADDR_WIDTH-1:0] result_rd_o,
   output logic                     result_we_o,
   output fir_xifu_wb2regfile_t     wb2regfile_o,
   output logic                     kill_o,
   output logic [$clog2(DEPTH):0]   occupancy_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fir_xifu_wbbuf_entry_t     entries_q [DEPTH];
   fir_xifu_wbbuf_entry_t     entries_d [DEPTH];
   logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]          count_q, count_d;

   logic                      push, pop;
   logic [DEPTH-1:0]          entry_valid;
   logic [DEPTH*ID_WIDTH-1:0] entry_id;
   logic [DEPTH:0]            cmt_match, mem_match;
   fir_xifu_wbbuf_entry_t     head_e;
   logic                      head_live, head_mem_ready, head_hs;

   assign ex2wb_ready_o = (count_q != CNT_W'(DEPTH));
   assign push          = ex2wb_valid_i & ex2wb_ready_o;
   assign occupancy_o   = count_q;

   // Flatten entry ids for the CAMs.
   always_comb begin
      entry_valid = '0;
      entry_id    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_valid[i]                        = entries_q[i].valid;
         entry_id[i*ID_WIDTH +: ID_WIDTH]      = ID_WIDTH'(entries_q[i].id);
      end
   end

   fir_xifu_id_match #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) u_commit_match (
      .valid_i       (commit_valid_i),
      .id_i          (commit_id_i),
      .entry_valid_i (entry_valid),
      .entry_id_i    (entry_id),
      .push_valid_i  (push),
      .push_id_i     (ex2wb_id_i),
      .match_o       (cmt_match)
   );

   fir_xifu_id_match #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) u_mem_match (
      .valid_i       (mem_result_valid_i),
      .id_i          (mem_result_id_i),
      .entry_valid_i (entry_valid),
      .entry_id_i    (entry_id),
      .push_valid_i  (push),
      .push_id_i     (ex2wb_id_i),
      .match_o       (mem_match)
   );

   // Head retire decision and outputs; driven from head registers only, so
   // a presented result stays stable until the core accepts it.
   always_comb begin
      head_e         = entries_q[head_q];
      head_live      = head_e.valid & head_e.committed & ~head_e.killed & ~rst_i;
      head_mem_ready = head_live & is_mem_instr(head_e.instr) & head_e.mem_done;
      head_hs        = head_mem_ready & result_ready_i;
      pop            = ~rst_i & head_e.valid &
                       (head_e.killed |
                        (head_e.committed & ((head_e.instr == XFIRDOTP) |
                                             (head_e.instr == INSTR_OTHER) |
                                             head_hs)));

      result_valid_o = head_mem_ready;
      result_we_o    = head_mem_ready;
      result_id_o    = head_mem_ready ? ID_WIDTH'(head_e.id) : '0;
      result_data_o  = head_mem_ready ? DATA_WIDTH'(head_e.result) : '0;
      result_rd_o    = head_mem_ready ? RF_ADDR_WIDTH'(head_e.rs1) : '0;

      wb2regfile_o = '0;
      if (head_live && (head_e.instr == XFIRDOTP)) begin
         wb2regfile_o.write  = 1'b1;
         wb2regfile_o.rd     = head_e.rd;
         wb2regfile_o.result = head_e.result;
      end else if (head_hs && (head_e.instr == XFIRLW)) begin
         wb2regfile_o.write  = 1'b1;
         wb2regfile_o.rd     = head_e.rd;
         wb2regfile_o.result = head_e.rdata;
      end

      kill_o = ~rst_i & commit_valid_i & commit_kill_i & (|cmt_match);
   end

   // Next-state: flag updates on matches, then pop at head, then push at tail.
   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (cmt_match[i]) begin
            if (commit_kill_i) entries_d[i].killed    = 1'b1;
            else               entries_d[i].committed = 1'b1;
         end
         if (mem_match[i]) begin
            entries_d[i].mem_done = 1'b1;
            entries_d[i].rdata    = FIR_XIFU_DATA_WIDTH'(mem_result_rdata_i);
         end
      end
      if (pop) begin
         entries_d[head_q].valid = 1'b0;
         head_d                  = head_q + PTR_W'(1);
      end
      // Never aliases the head slot: push is blocked while full.
      if (push) begin
         entries_d[tail_q].valid     = 1'b1;
         entries_d[tail_q].instr     = ex2wb_instr_i;
         entries_d[tail_q].id        = FIR_XIFU_ID_WIDTH'(ex2wb_id_i);
         entries_d[tail_q].result    = FIR_XIFU_DATA_WIDTH'(ex2wb_result_i);
         entries_d[tail_q].rd        = FIR_XIFU_RF_ADDR_WIDTH'(ex2wb_rd_i);
         entries_d[tail_q].rs1       = FIR_XIFU_RF_ADDR_WIDTH'(ex2wb_rs1_i);
         entries_d[tail_q].committed = cmt_match[DEPTH] & ~commit_kill_i;
         entries_d[tail_q].killed    = cmt_match[DEPTH] & commit_kill_i;
         entries_d[tail_q].mem_done  = mem_match[DEPTH];
         entries_d[tail_q].rdata     = mem_match[DEPTH] ?
                                       FIR_XIFU_DATA_WIDTH'(mem_result_rdata_i) : '0;
         tail_d                      = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         entries_q <= '{default: '0};
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

endmodule
